// File: rtl/game_round_controller.sv
// Round/lives/score/level controller for a small arcade game.
// Ports: clock, reset_n, start_key, round_won, round_lost in;
//   tick, round_start, level, lives, score, game_over, ctrl_state out.
module game_round_controller #(
  parameter int base_period = 67500,
  parameter int start_lives = 3,
  parameter int hold_ticks  = 100,
  parameter int max_level   = 7
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start_key,
  input  logic       round_won,
  input  logic       round_lost,
  output logic       tick,
  output logic       round_start,
  output logic [2:0] level,
  output logic [1:0] lives,
  output logic [7:0] score,
  output logic       game_over,
  output logic [1:0] ctrl_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    HOLD = 2'd2,
    OVER = 2'd3
  } state_t;

  localparam int PW =
    (base_period > 1) ? $clog2(base_period) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(base_period - 1);

  state_t state, state_next;

  logic key_s1, key_s2, key_s3;
  logic press;

  logic [PW-1:0] pre_cnt;
  logic b;

  logic [2:0] div_cnt;
  logic [2:0] div_lim;
  logic active;
  logic changed;
  logic fire;

  logic [7:0] hold_cnt;

  logic load;
  logic win_ev;
  logic lose_ev;
  logic lvl_up;
  logic [7:0] score_inc;

  // key_s3 holds the previous synchronized level for edge detection.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      key_s1 <= 1'b0;
      key_s2 <= 1'b0;
      key_s3 <= 1'b0;
    end else begin
      key_s1 <= start_key;
      key_s2 <= key_s1;
      key_s3 <= key_s2;
    end
  end

  assign press = key_s2 & ~key_s3;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt <= '0;
    end else if (b) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  assign b = (pre_cnt == P_LAST);

  always_comb begin
    state_next = state;
    load       = 1'b0;
    win_ev     = 1'b0;
    lose_ev    = 1'b0;
    unique case (state)
      IDLE: begin
        if (press) begin
          state_next = PLAY;
          load       = 1'b1;
        end
      end
      PLAY: begin
        if (round_lost) begin
          state_next = HOLD;
          lose_ev    = 1'b1;
        end else if (round_won) begin
          state_next = HOLD;
          win_ev     = 1'b1;
        end
      end
      HOLD: begin
        if (tick && hold_cnt <= 8'd1) begin
          state_next = (lives == 2'd0) ? OVER : PLAY;
        end
      end
      OVER: begin
        if (press) begin
          state_next = PLAY;
          load       = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    score_inc = (score == 8'hFF) ? score : score + 8'd1;
    lvl_up    = win_ev && (score != 8'hFF) &&
                (score_inc[1:0] == 2'd0) &&
                (level < 3'(max_level));
  end

  // Speed divider: level L needs (8 - L) base strobes per tick.
  assign active  = (state == PLAY) || (state == HOLD);
  assign div_lim = 3'd7 - level;
  assign changed = (state_next != state) || lvl_up;
  assign fire    = active && b && (div_cnt == div_lim) && !changed;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= 3'd0;
      tick    <= 1'b0;
    end else begin
      tick <= fire;
      if (changed || !active || fire) begin
        div_cnt <= 3'd0;
      end else if (b) begin
        div_cnt <= div_cnt + 3'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt <= 8'd0;
    end else if (state_next == HOLD && state != HOLD) begin
      hold_cnt <= 8'(hold_ticks);
    end else if (state == HOLD && tick && hold_cnt != 8'd0) begin
      hold_cnt <= hold_cnt - 8'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      score <= 8'd0;
      level <= 3'd0;
      lives <= 2'(start_lives);
    end else if (load) begin
      score <= 8'd0;
      level <= 3'd0;
      lives <= 2'(start_lives);
    end else if (lose_ev) begin
      if (lives != 2'd0) begin
        lives <= lives - 2'd1;
      end
    end else if (win_ev) begin
      score <= score_inc;
      if (lvl_up) begin
        level <= level + 3'd1;
      end
    end
  end

  // Both flags appear in the same cycle as the state they describe.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      round_start <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      round_start <= (state_next == PLAY) && (state != PLAY);
      game_over   <= (state_next == OVER);
    end
  end

  assign ctrl_state = state;

endmodule

// File: tb/tb_game_round_controller.sv
// Directed bench for game_round_controller.
// Small prescaler, two lives, two hold ticks.
module tb_game_round_controller;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       start_key = 1'b0;
  logic       round_won = 1'b0;
  logic       round_lost = 1'b0;
  logic       tick;
  logic       round_start;
  logic [2:0] level;
  logic [1:0] lives;
  logic [7:0] score;
  logic       game_over;
  logic [1:0] ctrl_state;

  int errors = 0;
  int checks = 0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_OVER = 2'd3;

  always #5 clock = ~clock;

  game_round_controller #(
    .base_period(4),
    .start_lives(2),
    .hold_ticks (2),
    .max_level  (7)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start_key  (start_key),
    .round_won  (round_won),
    .round_lost (round_lost),
    .tick       (tick),
    .round_start(round_start),
    .level      (level),
    .lives      (lives),
    .score      (score),
    .game_over  (game_over),
    .ctrl_state (ctrl_state)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic win();
    round_won = 1'b1;
    step();
    round_won = 1'b0;
  endtask

  task automatic lose();
    round_lost = 1'b1;
    step();
    round_lost = 1'b0;
  endtask

  task automatic wait_state(input logic [1:0] s,
                            input int budget,
                            input string tag);
    int n;
    n = 0;
    while (ctrl_state !== s && n < budget) begin
      step();
      n++;
    end
    chk(tag, 32'(ctrl_state), 32'(s));
  endtask

  task automatic tick_period(output int p);
    int n;
    n = 0;
    p = 0;
    while (tick !== 1'b1 && n < 300) begin
      step();
      n++;
    end
    if (tick === 1'b1) begin
      step();
      p = 1;
      while (tick !== 1'b1 && p < 300) begin
        step();
        p++;
      end
    end
  endtask

  task automatic count_ticks(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      if (tick === 1'b1) cnt++;
      step();
    end
  endtask

  // Score model: level is score/4 capped at 7.
  task automatic win_round(input int exp_score);
    int exp_lvl;
    exp_lvl = (exp_score / 4 > 7) ? 7 : exp_score / 4;
    win();
    chk("win_hold", 32'(ctrl_state), 32'(S_HOLD));
    chk("win_score", 32'(score), 32'(exp_score));
    chk("win_level", 32'(level), 32'(exp_lvl));
    wait_state(S_PLAY, 300, "win_back_play");
    chk("win_rstart", 32'(round_start), 32'd1);
  endtask

  initial begin
    int p;
    int cnt;
    int n;

    step();
    step();
    chk("rst_state", 32'(ctrl_state), 32'(S_IDLE));
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_rstart", 32'(round_start), 32'd0);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_lives", 32'(lives), 32'd2);
    chk("rst_over", 32'(game_over), 32'd0);
    reset_n = 1'b1;

    count_ticks(40, cnt);
    chk("idle_ticks", 32'(cnt), 32'd0);
    chk("idle_state", 32'(ctrl_state), 32'(S_IDLE));

    start_key = 1'b1;
    step();
    step();
    chk("press_lat2", 32'(ctrl_state), 32'(S_IDLE));
    step();
    chk("press_lat3", 32'(ctrl_state), 32'(S_PLAY));
    chk("start_rstart", 32'(round_start), 32'd1);
    chk("start_lives", 32'(lives), 32'd2);
    chk("start_score", 32'(score), 32'd0);
    chk("start_level", 32'(level), 32'd0);
    step();
    chk("rstart_once", 32'(round_start), 32'd0);
    start_key = 1'b0;

    tick_period(p);
    chk("period_l0", 32'(p), 32'd32);

    for (int i = 0; i < 3; i++) step();
    start_key = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("press_in_play", 32'(ctrl_state), 32'(S_PLAY));
    start_key = 1'b0;
    for (int i = 0; i < 3; i++) step();

    win();
    chk("w1_hold", 32'(ctrl_state), 32'(S_HOLD));
    chk("w1_score", 32'(score), 32'd1);
    step();
    win();
    chk("hold_ign_won", 32'(score), 32'd1);
    lose();
    chk("hold_ign_lost", 32'(lives), 32'd2);
    chk("hold_stay", 32'(ctrl_state), 32'(S_HOLD));
    wait_state(S_PLAY, 300, "w1_back_play");
    chk("w1_rstart", 32'(round_start), 32'd1);

    for (int s = 2; s <= 4; s++) win_round(s);
    chk("l1_level", 32'(level), 32'd1);
    tick_period(p);
    chk("period_l1", 32'(p), 32'd28);

    for (int s = 5; s <= 28; s++) win_round(s);
    chk("l7_level", 32'(level), 32'd7);
    tick_period(p);
    chk("period_l7", 32'(p), 32'd4);

    for (int s = 29; s <= 255; s++) win_round(s);
    chk("sat_score", 32'(score), 32'd255);
    win();
    chk("sat_hold", 32'(ctrl_state), 32'(S_HOLD));
    chk("sat_score2", 32'(score), 32'd255);
    chk("sat_level", 32'(level), 32'd7);
    wait_state(S_PLAY, 300, "sat_back_play");

    round_won = 1'b1;
    round_lost = 1'b1;
    step();
    round_won = 1'b0;
    round_lost = 1'b0;
    chk("both_hold", 32'(ctrl_state), 32'(S_HOLD));
    chk("both_lives", 32'(lives), 32'd1);
    chk("both_score", 32'(score), 32'd255);
    wait_state(S_PLAY, 300, "both_back_play");

    lose();
    chk("last_lives", 32'(lives), 32'd0);
    chk("last_hold", 32'(ctrl_state), 32'(S_HOLD));
    n = 0;
    cnt = 0;
    while (ctrl_state !== S_OVER && n < 300) begin
      if (tick === 1'b1) cnt++;
      step();
      n++;
    end
    chk("over_state", 32'(ctrl_state), 32'(S_OVER));
    chk("hold_ticks", 32'(cnt), 32'd2);
    chk("over_flag", 32'(game_over), 32'd1);
    count_ticks(20, cnt);
    chk("over_ticks", 32'(cnt), 32'd0);

    start_key = 1'b1;
    step();
    step();
    chk("over_lat2", 32'(ctrl_state), 32'(S_OVER));
    step();
    chk("restart_state", 32'(ctrl_state), 32'(S_PLAY));
    chk("restart_lives", 32'(lives), 32'd2);
    chk("restart_score", 32'(score), 32'd0);
    chk("restart_level", 32'(level), 32'd0);
    chk("restart_over", 32'(game_over), 32'd0);
    chk("restart_rstart", 32'(round_start), 32'd1);
    start_key = 1'b0;

    win();
    chk("mid_hold", 32'(ctrl_state), 32'(S_HOLD));
    chk("mid_score", 32'(score), 32'd1);
    step();
    step();
    reset_n = 1'b0;
    #1;
    chk("arst_state", 32'(ctrl_state), 32'(S_IDLE));
    chk("arst_score", 32'(score), 32'd0);
    chk("arst_lives", 32'(lives), 32'd2);
    chk("arst_level", 32'(level), 32'd0);
    chk("arst_tick", 32'(tick), 32'd0);
    chk("arst_rstart", 32'(round_start), 32'd0);
    chk("arst_over", 32'(game_over), 32'd0);
    step();
    step();
    reset_n = 1'b1;
    step();
    chk("post_rst_idle", 32'(ctrl_state), 32'(S_IDLE));
    count_ticks(40, cnt);
    chk("post_rst_ticks", 32'(cnt), 32'd0);
    chk("post_rst_state", 32'(ctrl_state), 32'(S_IDLE));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
